// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and default constants for the simulation-control monitor.
// Revision: 1.0
`default_nettype none

package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } sim_ctrl_state_e;

    localparam int unsigned DEF_END_ADDR  = 'h3fff;
    localparam logic [31:0] DEF_END_CODE  = 32'hFFFF_FFFF;
    localparam int unsigned DEF_MAX_CYCLE = 300000;

    typedef struct packed {
        logic done;
        logic pass;
        logic timeout;
    } sim_ctrl_status_t;

endpackage

`default_nettype wire

// File: rtl/sim_ctrl_arb.sv
// sim_ctrl_arb: combinational lowest-index priority encoder over per-port hit bits.
// Revision: 1.0
`default_nettype none

module sim_ctrl_arb #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] hit,
    output logic                 any_hit,
    output logic [IDX_W-1:0]     hit_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        any_hit = |hit;
        hit_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = IDX_W'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sim_ctrl_mon.sv
// sim_ctrl_mon: snoops DM write ports for the exit store, counts run cycles, runs a watchdog.
// Optional per-port accepted-write counters enabled by macro SIM_CTRL_WR_CNT_EN. Revision: 1.0
`default_nettype none

module sim_ctrl_mon
    import sim_ctrl_pkg::*;
#(
    parameter int                 NUM_PORTS = 2,
    parameter int                 ADDR_W    = 14,
    parameter int                 DATA_W    = 32,
    parameter int                 CNT_W     = 64,
    parameter logic [ADDR_W-1:0]  END_ADDR  = ADDR_W'(DEF_END_ADDR),
    parameter logic [DATA_W-1:0]  END_CODE  = DATA_W'(DEF_END_CODE),
    parameter int unsigned        MAX_CYCLE = DEF_MAX_CYCLE,
    parameter int                 PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_PORTS-1:0]            wr_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]     wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     wr_data,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   wr_strb,
    output logic                            running,
    output logic                            done,
    output logic                            pass,
    output logic                            timeout,
    output logic [DATA_W-1:0]               exit_code,
    output logic [PORT_W-1:0]               exit_port,
    output logic [CNT_W-1:0]                total_cycle,
    output logic [NUM_PORTS*32-1:0]         wr_count
);

    localparam int              STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLE - 1);

    sim_ctrl_state_e  state;
    sim_ctrl_status_t status;

    logic [NUM_PORTS-1:0] hit;
    logic                 any_hit;
    logic [PORT_W-1:0]    hit_idx;
    logic [DATA_W-1:0]    win_data;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_hit
            assign hit[p] = wr_en[p]
                         && (wr_addr[p*ADDR_W +: ADDR_W] == END_ADDR)
                         && (&wr_strb[p*STRB_W +: STRB_W]);
        end
    endgenerate

    sim_ctrl_arb #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (PORT_W)
    ) u_arb (
        .hit     (hit),
        .any_hit (any_hit),
        .hit_idx (hit_idx)
    );

    assign win_data = wr_data[int'(hit_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            status      <= '0;
            running     <= 1'b0;
            exit_code   <= '0;
            exit_port   <= '0;
            total_cycle <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (total_cycle != '1) total_cycle <= total_cycle + CNT_W'(1);
                    // An end hit on the watchdog's final edge still counts as a clean finish.
                    if (any_hit) begin
                        state          <= DONE;
                        running        <= 1'b0;
                        status.done    <= 1'b1;
                        status.pass    <= (win_data == END_CODE);
                        exit_code      <= win_data;
                        exit_port      <= hit_idx;
                    end else if (total_cycle == LIMIT) begin
                        state          <= TIMEOUT;
                        running        <= 1'b0;
                        status.timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done    = status.done;
    assign pass    = status.pass;
    assign timeout = status.timeout;

`ifdef SIM_CTRL_WR_CNT_EN
    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_wr_cnt
            logic [31:0] cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                            cnt <= '0;
                else if (state == RUN && wr_en[p])  cnt <= cnt + 32'd1;
            end
            assign wr_count[p*32 +: 32] = cnt;
        end
    endgenerate
`else
    assign wr_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sim_ctrl_mon.sv
// tb_sim_ctrl_mon: directed self-checking bench for sim_ctrl_mon (two ports, MAX_CYCLE=20).
// Revision: 1.0
`default_nettype none

module tb_sim_ctrl_mon;

    localparam int NP = 2;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int CW = 64;
    localparam logic [AW-1:0] EA = 14'h3fff;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NP-1:0]     wr_en = '0;
    logic [NP*AW-1:0]  wr_addr = '0;
    logic [NP*DW-1:0]  wr_data = '0;
    logic [NP*DW/8-1:0] wr_strb = '0;
    logic              running, done, pass, timeout;
    logic [DW-1:0]     exit_code;
    logic [0:0]        exit_port;
    logic [CW-1:0]     total_cycle;
    logic [NP*32-1:0]  wr_count;

    int n_cmp = 0;
    int n_err = 0;

    sim_ctrl_mon #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CNT_W     (CW),
        .END_ADDR  (EA),
        .END_CODE  (32'hFFFF_FFFF),
        .MAX_CYCLE (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_strb     (wr_strb),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .exit_port   (exit_port),
        .total_cycle (total_cycle),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // One write cycle on both ports; inputs cleared after the sampling edge.
    task automatic wr2(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [3:0] s0, input logic [3:0] s1);
        wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0}; wr_strb = {s1, s0};
        tick(1);
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    endtask

    initial begin
        do_reset();
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_exit_code", 64'(exit_code), 64'd0);
        chk("rst_total", total_cycle, 64'd0);

        // Pass store on port0 at the 10th RUN edge
        start_run();
        chk("t1_running", 64'(running), 64'd1);
        chk("t1_total0", total_cycle, 64'd0);
        tick(9);
        wr2(2'b01, EA, 14'h0, 32'hFFFF_FFFF, 32'h0, 4'hF, 4'h0);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_port", 64'(exit_port), 64'd0);
        chk("t1_code", 64'(exit_code), 64'hFFFF_FFFF);
        chk("t1_total", total_cycle, 64'd10);
        chk("t1_running0", 64'(running), 64'd0);
        start_run();
        wr2(2'b10, 14'h0, EA, 32'h0, 32'h7, 4'h0, 4'hF);
        chk("t1_term_total", total_cycle, 64'd10);
        chk("t1_term_code", 64'(exit_code), 64'hFFFF_FFFF);
        chk("t1_term_running", 64'(running), 64'd0);

        // Fail code on port1 at 3rd edge
        do_reset();
        start_run();
        tick(2);
        wr2(2'b10, 14'h0, EA, 32'h0, 32'h5, 4'h0, 4'hF);
        chk("t2_done", 64'(done), 64'd1);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_code", 64'(exit_code), 64'd5);
        chk("t2_port", 64'(exit_port), 64'd1);
        chk("t2_total", total_cycle, 64'd3);

        // Simultaneous hits: lowest index wins
        do_reset();
        start_run();
        wr2(2'b11, EA, EA, 32'h1, 32'h2, 4'hF, 4'hF);
        chk("t3_port", 64'(exit_port), 64'd0);
        chk("t3_code", 64'(exit_code), 64'd1);
        chk("t3_total", total_cycle, 64'd1);

        // Partial strobe is not a hit; the full write 3 cycles later is
        do_reset();
        start_run();
        wr2(2'b01, EA, 14'h0, 32'hFFFF_FFFF, 32'h0, 4'h3, 4'h0);
        chk("t4_partial_done", 64'(done), 64'd0);
        chk("t4_partial_running", 64'(running), 64'd1);
        tick(2);
        wr2(2'b01, EA, 14'h0, 32'h0000_00AA, 32'h0, 4'hF, 4'h0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_code", 64'(exit_code), 64'hAA);
        chk("t4_total", total_cycle, 64'd4);

        // Watchdog expiry on the 20th RUN edge
        do_reset();
        start_run();
        tick(19);
        chk("t5_pre_timeout", 64'(timeout), 64'd0);
        chk("t5_pre_total", total_cycle, 64'd19);
        tick(1);
        chk("t5_timeout", 64'(timeout), 64'd1);
        chk("t5_total", total_cycle, 64'd20);
        chk("t5_running", 64'(running), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        tick(3);
        chk("t5_frozen", total_cycle, 64'd20);

        // Hit on the same edge as expiry: done wins
        do_reset();
        start_run();
        tick(19);
        wr2(2'b01, EA, 14'h0, 32'hFFFF_FFFF, 32'h0, 4'hF, 4'h0);
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_timeout", 64'(timeout), 64'd0);
        chk("t6_total", total_cycle, 64'd20);

        // Asynchronous reset mid-run
        do_reset();
        start_run();
        tick(7);
        #2 rst = 1'b1;
        #1;
        chk("t7_running", 64'(running), 64'd0);
        chk("t7_total", total_cycle, 64'd0);
        rst = 1'b0;
        tick(3);
        chk("t7_idle_running", 64'(running), 64'd0);
        chk("t7_idle_total", total_cycle, 64'd0);

        // Writes in IDLE neither hit nor count
        do_reset();
        wr2(2'b01, EA, 14'h0, 32'hFFFF_FFFF, 32'h0, 4'hF, 4'h0);
        wr2(2'b01, 14'h10, 14'h0, 32'h1, 32'h0, 4'hF, 4'h0);
        chk("t8_idle_done", 64'(done), 64'd0);
        start_run();
        for (int i = 0; i < 3; i++) wr2(2'b01, 14'(i + 1), 14'h0, 32'(i), 32'h0, 4'hF, 4'h0);
`ifdef SIM_CTRL_WR_CNT_EN
        chk("t8_cnt0", 64'(wr_count[31:0]), 64'd3);
`else
        chk("t8_cnt0", 64'(wr_count[31:0]), 64'd0);
`endif
        chk("t8_cnt1", 64'(wr_count[63:32]), 64'd0);
        chk("t8_total", total_cycle, 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
